// File: rtl/btog_counter.sv
// Binary counter with a registered Gray-code twin, terminal-count flag and wrap pulse.
// Define BTOG_DOWN_EN to add the dir port and down counting; the default build counts up only.
module btog_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_b,
`ifdef BTOG_DOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r[WIDTH-1] = v[WIDTH-1];
        for (int i = 0; i < WIDTH - 1; i++) begin
            r[i] = v[i+1] ^ v[i];
        end
        return r;
    endfunction

    logic [WIDTH-1:0] b_step;
    logic             step_wraps;
    logic [WIDTH-1:0] term_val;

`ifdef BTOG_DOWN_EN
    always_comb begin
        b_step     = dir ? (b - ONE) : (b + ONE);
        step_wraps = dir ? (b == '0) : (b == ALL_ONES);
        term_val   = dir ? '0 : ALL_ONES;
    end
`else
    always_comb begin
        b_step     = b + ONE;
        step_wraps = (b == ALL_ONES);
        term_val   = ALL_ONES;
    end
`endif

    logic [WIDTH-1:0] b_nxt;
    logic             wrap_nxt;
    logic             tc_nxt;

    // Load beats count; with neither strobe the state holds and wrap drops.
    always_comb begin
        b_nxt    = b;
        wrap_nxt = 1'b0;
        tc_nxt   = tc;
        if (load) begin
            b_nxt  = load_b;
            tc_nxt = (load_b == term_val);
        end else if (en) begin
            b_nxt    = b_step;
            wrap_nxt = step_wraps;
            tc_nxt   = (b_step == term_val);
        end
    end

    // g is loaded from the Gray code of the next value so it never lags b.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b    <= '0;
            g    <= '0;
            tc   <= 1'b0;
            wrap <= 1'b0;
        end else begin
            b    <= b_nxt;
            g    <= to_gray(b_nxt);
            tc   <= tc_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_btog_counter.sv
// Directed bench for btog_counter: an arithmetic reference model checked every cycle,
// plus hand-computed expectations for the documented scenarios.
module tb_btog_counter;

    localparam int W = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_b = '0;
    logic         dir = 1'b0;
    logic [W-1:0] b, g;
    logic         tc, wrap;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    btog_counter #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .load   (load),
        .load_b (load_b),
`ifdef BTOG_DOWN_EN
        .dir    (dir),
`endif
        .b      (b),
        .g      (g),
        .tc     (tc),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: plain modular arithmetic on an integer count.
    int  mb = 0, mprev = 0;
    bit  mw = 0, mdir = 0, mstep = 0;

    function automatic bit cur_dir();
`ifdef BTOG_DOWN_EN
        return dir;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        mstep = 1'b0;
        if (rst) begin
            mb = 0; mw = 0; mdir = 0;
        end else if (load) begin
            mb = int'(load_b); mw = 0; mdir = cur_dir();
        end else if (en) begin
            mprev = mb;
            mstep = 1'b1;
            mdir  = cur_dir();
            if (mdir) begin
                mw = (mb == 0);
                mb = (mb + MAXV) % (MAXV + 1);
            end else begin
                mw = (mb == MAXV);
                mb = (mb + 1) % (MAXV + 1);
            end
        end else begin
            mw = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_b", 32'(b), 32'(mb));
            chk("model_g", 32'(g), 32'(mb ^ (mb >> 1)));
            chk("model_tc", 32'(tc), 32'(mb == (mdir ? 0 : MAXV)));
            chk("model_wrap", 32'(wrap), 32'(mw));
            if (mstep)
                chk("gray_one_bit", 32'($countones(g ^ W'(mprev ^ (mprev >> 1)))), 32'd1);
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] gseq [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    initial begin
        #2 rst = 1'b1;
        chk_en = 1'b1;
        #5;
        chk("rst_b", 32'(b), 32'd0);
        chk("rst_g", 32'(g), 32'd0);
        chk("rst_tc", 32'(tc), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;

        // Full up sequence with wrap back to zero.
        chk("seq_g0", 32'(g), 32'(gseq[0]));
        for (int k = 1; k < 17; k++) begin
            edge1();
            chk("seq_g", 32'(g), 32'(gseq[k]));
            chk("seq_tc", 32'(tc), 32'(k == 15));
            chk("seq_wrap", 32'(wrap), 32'(k == 16));
        end
        en = 1'b0;
        edge1();
        chk("wrap_drops", 32'(wrap), 32'd0);

        // Load wins over enable, then counts on.
        load = 1'b1; load_b = 4'b1010; en = 1'b1;
        edge1();
        chk("load_b", 32'(b), 32'hA);
        chk("load_g", 32'(g), 32'hF);
        chk("load_wrap", 32'(wrap), 32'd0);
        load = 1'b0;
        edge1();
        chk("after_load_b", 32'(b), 32'hB);
        chk("after_load_g", 32'(g), 32'hE);

        // Hold with en low.
        load = 1'b1; load_b = 4'b0110; en = 1'b0;
        edge1();
        load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            edge1();
            chk("hold_b", 32'(b), 32'h6);
            chk("hold_g", 32'(g), 32'h5);
            chk("hold_tc", 32'(tc), 32'd0);
        end
        load = 1'b1; load_b = 4'b1111;
        edge1();
        chk("load_ff_g", 32'(g), 32'h8);
        chk("load_ff_tc", 32'(tc), 32'd1);
        load = 1'b0;
        edge1();
        chk("hold_ff_tc", 32'(tc), 32'd1);

        // Loading the wrap target never pulses wrap.
        load = 1'b1; load_b = 4'b0000; en = 1'b1;
        edge1();
        chk("load0_b", 32'(b), 32'd0);
        chk("load0_wrap", 32'(wrap), 32'd0);
        chk("load0_tc", 32'(tc), 32'd0);

        // Asynchronous reset between edges at b=0111.
        load_b = 4'b0110;
        edge1();
        load = 1'b0;
        edge1();
        chk("pre_rst_b", 32'(b), 32'h7);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_b", 32'(b), 32'd0);
        chk("async_rst_g", 32'(g), 32'd0);
        chk("async_rst_wrap", 32'(wrap), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        edge1();
        chk("resume_b", 32'(b), 32'd1);
        chk("resume_g", 32'(g), 32'd1);
        en = 1'b0;

`ifdef BTOG_DOWN_EN
        // Down count through zero.
        load = 1'b1; load_b = 4'b0001; dir = 1'b1;
        edge1();
        load = 1'b0; en = 1'b1;
        edge1();
        chk("down_b0", 32'(b), 32'd0);
        chk("down_tc0", 32'(tc), 32'd1);
        edge1();
        chk("down_bF", 32'(b), 32'hF);
        chk("down_gF", 32'(g), 32'h8);
        chk("down_wrapF", 32'(wrap), 32'd1);
        edge1();
        chk("down_bE", 32'(b), 32'hE);
        chk("down_gE", 32'(g), 32'h9);
        chk("down_wrapE", 32'(wrap), 32'd0);
        en = 1'b0; dir = 1'b0;
`endif

        // Mixed enable/load pattern checked by the model alone.
        for (int i = 0; i < 48; i++) begin
            en     = ((i % 3) != 2);
            load   = ((i % 11) == 5);
            load_b = W'((i * 7) % (MAXV + 1));
`ifdef BTOG_DOWN_EN
            dir    = ((i / 8) % 2 == 1);
`endif
            edge1();
        end
        load = 1'b0; en = 1'b0;
        edge1();
        @(negedge clk);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
